div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-002 rst  input  1  synchronous active-high reset.
REQ-003 signed_div_i  input  1  1 = signed division, 0 = unsigned; sampled with start_i.
REQ-004 opdata1_i  input  32  dividend; sampled with start_i.
REQ-005 opdata2_i  input  32  divisor; sampled with start_i.
REQ-006 start_i  input  1  DivStart/DivStop request from EX; held high until ready_o is seen.
REQ-007 annul_i  input  1  cancel the in-flight division (branch/exception flush).
REQ-008 result_o  output  64  [63:32] = remainder (to HI), [31:0] = quotient (to LO).
REQ-009 ready_o  output  1  DivResultReady while result_o is valid.

Function
REQ-010 The FSM SHALL have four states: FREE, BYZERO, ON, END.
REQ-011 In FREE with start_i=1 and annul_i=0, the FSM SHALL sample the operands and go to BYZERO if opdata2_i==0, else to ON.
- On sampling, cnt SHALL be cleared.
- When signed_div_i=1, negative operands SHALL be latched as their two's-complement magnitude.
REQ-012 ON SHALL run a restoring radix-2 algorithm, one quotient bit per cycle, for exactly 32 iteration edges.
- Datapath: 65-bit {remainder, dividend} shift register.
- Each step SHALL do a 33-bit trial subtraction minuend[63:32] - divisor.
- Borrow: shift in 0. No borrow: replace the high word with the difference and shift in 1.
REQ-013 After the 32nd iteration the FSM SHALL go to END, registering result_o and ready_o=1 on that edge.
- Latency: ready_o rises exactly 33 clock edges after the start-sampling edge.
REQ-014 Signed fix-up SHALL be applied when result_o is registered (signed_div_i=1 only).
- Quotient SHALL be negated when the operand signs differ.
- Remainder SHALL take the sign of the dividend.
- Unsigned division SHALL apply no fix-up.
REQ-015 BYZERO SHALL go to END on the next edge with result_o=0.
- ready_o rises 2 edges after start is sampled.
REQ-016 In END, ready_o and result_o SHALL hold while start_i=1.
- When start_i=0, the FSM SHALL return to FREE, clearing ready_o and result_o on that edge.
REQ-017 In ON or BYZERO, annul_i=1 or start_i=0 SHALL abort: return to FREE next edge, ready_o=0, result_o=0, no partial result exposed.
REQ-018 annul_i SHALL take priority over start_i in every state; FREE with annul_i=1 SHALL not start.
REQ-019 Operand changes after the sampling edge SHALL NOT affect the result.
REQ-020 In FREE, ready_o and result_o SHALL be 0.
REQ-021 The most-negative dividend 0x80000000 SHALL divide correctly, since the magnitude path is 33-bit safe.

Reset
REQ-022 rst=1 at a clock edge SHALL force FREE, cnt=0, ready_o=0 and result_o=0, including mid-ON, regardless of every other input.
REQ-023 The first start sampled after reset release SHALL behave per REQ-011.

Structure
REQ-024 State encodings (DivFree, DivByZero, DivOn, DivEnd) and the control constants SHALL live in the shared defines.v.
- Control constants: DivStart, DivStop, DivResultReady, DivResultNotReady, and the RegBus/DoubleRegBus widths.
REQ-025 The block SHALL be self-contained (no sub-module); the trial subtraction is an internal 33-bit continuous assignment.
REQ-026 All state, counter, shift register and outputs SHALL be updated in a single clocked process; next-state decode may be combinational.

Verification
REQ-027 Unsigned 100 / 7 (start held) -> at edge 33 ready_o=1, result_o=0x00000002_0000000E.
REQ-028 Signed -7 / 2 (0xFFFFFFF9, 0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD; signed 7 / -2 -> 0x00000001_FFFFFFFD.
REQ-029 Divide by zero, 0x1234 / 0 -> ready_o=1 at edge 2 with result_o=0; start_i dropped -> ready_o=0 next edge, FSM FREE.
REQ-030 Annul mid-operation, 0xFFFFFFFF / 3 with annul_i pulsed at iteration 10 -> FREE next edge, ready_o never rises.
- A following unsigned 0xFFFFFFFF / 3 SHALL give 0x00000000_55555555 at edge 33.
REQ-031 Hold and back-to-back: start held 5 cycles past ready -> result stable.
- Drop start one cycle, then a new 50 / 5 -> 0x00000000_0000000A at edge 33 of the new request.
REQ-032 Reset mid-ON at iteration 20 -> all outputs 0 next edge; a subsequent 9 / 4 unsigned -> 0x00000001_00000002.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider: FSM state encodings,
// handshake constants, bus widths and the sign fix-up helper.
package div_seq_pkg;

  localparam int REG_BUS        = 32;
  localparam int DOUBLE_REG_BUS = 64;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  // Iteration counter value of the 32nd (final) restoring step.
  localparam logic [5:0] DIV_LAST_ITER = 6'd31;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  // Two's-complement negate when neg is set, pass-through otherwise.
  // Used both to take operand magnitudes and to restore result signs.
  function automatic logic [REG_BUS-1:0] cond_negate(input logic [REG_BUS-1:0] v,
                                                     input logic               neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_seq.sv
// Sequential restoring radix-2 divider (32-bit, signed or unsigned).
// One quotient bit per cycle; remainder in result_o[63:32], quotient in
// result_o[31:0]. Outputs are registered and held while start_i stays high.
module div_seq
  import div_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  div_state_e                  state_q,    state_d;
  logic [5:0]                  cnt_q,      cnt_d;
  logic [DOUBLE_REG_BUS:0]     dividend_q, dividend_d;
  logic [REG_BUS-1:0]          divisor_q,  divisor_d;
  logic                        neg_quot_q, neg_quot_d;
  logic                        neg_rem_q,  neg_rem_d;
  logic [DOUBLE_REG_BUS-1:0]   result_q,   result_d;
  logic                        ready_q,    ready_d;

  logic [REG_BUS:0]            div_temp_s;
  logic [DOUBLE_REG_BUS:0]     step_s;
  logic [REG_BUS-1:0]          quot_s;
  logic [REG_BUS-1:0]          rem_s;
  logic                        op1_neg_s;
  logic                        op2_neg_s;
  logic                        abort_s;

  // 33-bit trial subtraction: bit 32 set means the minuend was smaller (borrow).
  assign div_temp_s = {1'b0, dividend_q[63:32]} - {1'b0, divisor_q};

  assign op1_neg_s = signed_div_i & opdata1_i[31];
  assign op2_neg_s = signed_div_i & opdata2_i[31];
  assign abort_s   = annul_i | (start_i == DIV_STOP);

  // One restoring step of the {remainder, dividend} shift register and the
  // sign-corrected result it would yield if this were the last step.
  always_comb begin
    if (div_temp_s[32]) begin
      step_s = {dividend_q[63:0], 1'b0};
    end else begin
      step_s = {div_temp_s[31:0], dividend_q[31:0], 1'b1};
    end
    quot_s = cond_negate(step_s[31:0], neg_quot_q);
    rem_s  = cond_negate(step_s[64:33], neg_rem_q);
  end

  // Next-state, datapath and output decode for the divider FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;
    case (state_q)
      DIV_FREE: begin
        result_d = 64'd0;
        ready_d  = DIV_RESULT_NOT_READY;
        if ((start_i == DIV_START) && !annul_i) begin
          cnt_d      = 6'd0;
          neg_quot_d = op1_neg_s ^ op2_neg_s;
          neg_rem_d  = op1_neg_s;
          divisor_d  = cond_negate(opdata2_i, op2_neg_s);
          dividend_d = {32'd0, cond_negate(opdata1_i, op1_neg_s), 1'b0};
          if (opdata2_i == 32'd0) begin
            state_d = DIV_BYZERO;
          end else begin
            state_d = DIV_ON;
          end
        end else begin
          state_d = DIV_FREE;
        end
      end
      DIV_BYZERO: begin
        if (abort_s) begin
          state_d  = DIV_FREE;
          result_d = 64'd0;
          ready_d  = DIV_RESULT_NOT_READY;
        end else begin
          state_d  = DIV_END;
          result_d = 64'd0;
          ready_d  = DIV_RESULT_READY;
        end
      end
      DIV_ON: begin
        if (abort_s) begin
          state_d  = DIV_FREE;
          cnt_d    = 6'd0;
          result_d = 64'd0;
          ready_d  = DIV_RESULT_NOT_READY;
        end else begin
          dividend_d = step_s;
          if (cnt_q == DIV_LAST_ITER) begin
            state_d  = DIV_END;
            cnt_d    = 6'd0;
            result_d = {rem_s, quot_s};
            ready_d  = DIV_RESULT_READY;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      DIV_END: begin
        if (abort_s) begin
          state_d  = DIV_FREE;
          result_d = 64'd0;
          ready_d  = DIV_RESULT_NOT_READY;
        end else begin
          state_d = DIV_END;
        end
      end
      default: begin
        state_d  = DIV_FREE;
        cnt_d    = 6'd0;
        result_d = 64'd0;
        ready_d  = DIV_RESULT_NOT_READY;
      end
    endcase
  end

  // All divider state, counter, shift register and outputs update here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DIV_FREE;
      cnt_q      <= 6'd0;
      dividend_q <= 65'd0;
      divisor_q  <= 32'd0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= 64'd0;
      ready_q    <= DIV_RESULT_NOT_READY;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: drivers push expected results (from plain
// integer division) with the edge on which ready_o must appear; a monitor on
// the falling edge pops and compares, and polices idle/hold behaviour.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [63:0] res;
    int          edge_n;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  logic [63:0] held_res;
  logic        prev_ready = 1'b0;

  div_seq dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: truncating division, remainder takes the dividend's sign.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint q;
    longint r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = longint'($signed(a)) % longint'($signed(b));
    end else begin
      q = longint'({32'd0, a}) / longint'({32'd0, b});
      r = longint'({32'd0, a}) % longint'({32'd0, b});
    end
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor: result/latency on ready rise, stability while held, zero when idle.
  always @(negedge clk) begin
    if (ready_o === 1'b1 && prev_ready !== 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready: got ready_o=1 result_o=%h at edge %0d, required no result", result_o, cyc);
      end else begin
        cur = exp_q.pop_front();
        if (result_o !== cur.res) begin
          errors++;
          $display("FAIL result: got %h, required %h", result_o, cur.res);
        end
        checks++;
        if (cyc != cur.edge_n) begin
          errors++;
          $display("FAIL latency: ready_o rose at edge %0d, required edge %0d", cyc, cur.edge_n);
        end
      end
      held_res = result_o;
    end else if (ready_o === 1'b1) begin
      checks++;
      if (result_o !== held_res) begin
        errors++;
        $display("FAIL hold: result_o changed to %h, required %h", result_o, held_res);
      end
    end else if (cyc > 0) begin
      checks++;
      if (result_o !== 64'd0 || ready_o !== 1'b0) begin
        errors++;
        $display("FAIL idle_zero: got ready_o=%b result_o=%h, required 0/0", ready_o, result_o);
      end
    end
    prev_ready = ready_o;
  end

  // Issue one division, optionally blocked by annul in FREE first, then hold.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int hold, input int pre_annul);
    logic [63:0] e;
    bit          seen;
    e = ref_div(a, b, s);
    @(negedge clk);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = (pre_annul > 0);
    if (pre_annul > 0) begin
      repeat (pre_annul) @(negedge clk);
      annul_i = 1'b0;
    end
    exp_q.push_back('{res: e, edge_n: cyc + 1 + ((b == 32'd0) ? 1 : 32)});
    @(posedge clk);
    #1;
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = 1'($urandom_range(0, 1));
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL timeout: ready_o=0 after 40 cycles for %h / %h signed=%b, required 1", a, b, s);
      exp_q.delete();
    end
    repeat (hold) @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL release: ready_o=%b after start dropped, required 0", ready_o);
    end
  endtask

  // Start a division and kill it after iter iterations with annul or reset.
  task automatic abort_div(input logic [31:0] a, input logic [31:0] b, input int iter,
                           input bit use_rst);
    int s_edge;
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    s_edge       = cyc + 1;
    while (cyc < s_edge + iter) @(negedge clk);
    if (use_rst) rst = 1'b1;
    else         annul_i = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    annul_i = 1'b0;
    start_i = 1'b0;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++;
      $display("FAIL abort: got ready_o=%b result_o=%h, required 0/0", ready_o, result_o);
    end
    repeat (40) @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      errors++;
      $display("FAIL reset: got ready_o=%b result_o=%h, required 0/0", ready_o, result_o);
    end
    start_i = 1'b0;
    rst     = 1'b0;
    @(negedge clk);

    run_div(32'd100, 32'd7, 1'b0, 0, 0);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1, 0);
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 0, 0);
    run_div(32'h0000_1234, 32'd0, 1'b0, 0, 0);
    run_div(32'h0000_1234, 32'd0, 1'b1, 2, 0);
    abort_div(32'hFFFF_FFFF, 32'd3, 10, 1'b0);
    run_div(32'hFFFF_FFFF, 32'd3, 1'b0, 5, 0);
    run_div(32'd50, 32'd5, 1'b0, 0, 0);
    abort_div(32'hDEAD_BEEF, 32'd17, 20, 1'b1);
    run_div(32'd9, 32'd4, 1'b0, 0, 0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0);
    run_div(32'h8000_0000, 32'd2, 1'b1, 0, 0);
    run_div(32'h8000_0000, 32'd3, 1'b0, 0, 3);
    run_div(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 0, 0);
    run_div(32'hFFFF_FFF0, 32'hFFFF_FFFD, 1'b1, 0, 0);

    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'($urandom_range(1, 15));
        1:       b = 32'd0;
        2:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      run_div(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 1));
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected results never appeared, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
